anc_mc_sequencer: RTL and testbench
===================================

Name: anc_mc_sequencer

Overview:
- Multi-channel successor to the single-channel ANC controller path.
- Accepts tagged (e, x, a, u) samples for CH channels and applies a per-channel programmable x delay.
- Computes the LMS weight adjust, then time-multiplexes one shared FIR/weight engine through a go/done handshake.
- Returns tagged output samples. Adds a fir_done watchdog and per-channel delay-fill tracking.

Parameters:
- CH, 2, number of audio channels (>=1); CHW = max(1, clog2(CH)).
- DW, 16, sample / step-size / weight-adjust width (signed).
- DSW, 5, delay select width; delay line depth = 2^DSW per channel.
- TMO, 1023, max cycles to wait for fir_done before timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- freeze  in  1  holds all state (scan/debug freeze).
- init_done  in  1  engine weights initialised; no sample is accepted before it is 1.
- prog_delay_sel  in  DSW  x delay in samples, 0..2^DSW-1.
- bypass_mode_sel  in  1  1 = weights injected externally; weight adjust forced to 0.
- in_valid  in  1  input sample valid.
- in_ready  out  1  sequencer can accept a sample.
- in_ch  in  CHW  channel tag of the input sample.
- e_in, x_in, a_in, u_in  in  DW each  error, reference, desired, step size (signed).
- fir_go  out  1  one-cycle start pulse to the engine.
- fir_ch  out  CHW  channel being processed.
- fir_x, fir_a, fir_wadj  out  DW each  delayed x, desired, weight adjust; held stable from fir_go until fir_done.
- fir_done  in  1  engine finished; fir_y is valid in the same cycle.
- fir_y  in  DW  engine output sample.
- out_valid  out  1  one-cycle output pulse; no backpressure.
- out_ch  out  CHW  output channel tag.
- out_sample  out  DW  output sample.
- err_tmo  out  1  sticky timeout flag, cleared only by rst.

Behaviour:
- Reset (sync, rst=1 at an edge): all outputs 0 and state=IDLE. Fill counters, delay write pointers and the watchdog are cleared. Delay RAM contents are not cleared (see fill rule).
- FSM states: IDLE, READY, CALC, ISSUE, WAIT, OUT.
  - IDLE -> READY when init_done=1.
  - READY: in_ready=1 iff !freeze. An accept (in_valid && in_ready) latches the sample and in_ch, then -> CALC. An in_ch >= CH is accepted and dropped, staying in READY.
  - CALC (1 cycle):
    - Write x_in into the channel's delay line.
    - Read the x written prog_delay_sel samples earlier for that channel; delay 0 returns the current x_in.
    - Compute wadj.
  - ISSUE: fir_go=1 for exactly one cycle, fir_* driven; -> WAIT.
  - WAIT: on fir_done, latch fir_y and -> OUT. If the watchdog reaches TMO with no fir_done: set err_tmo, out_sample=0, -> OUT.
  - OUT: out_valid=1 for one cycle with out_ch/out_sample; -> READY. If init_done=0, -> IDLE instead.
- Latency:
  - Accept at edge T; fir_go high in cycle T+2.
  - fir_done in cycle D gives out_valid in cycle D+1; in_ready rises again in cycle D+2.
  - One sample in flight at a time.
- Weight adjust arithmetic:
  - p = e*u as a 2*DW signed product.
  - wadj = sat_DW((p + 2^(DW-2)) >>> (DW-1)), i.e. round-half-up, saturated to [-2^(DW-1), 2^(DW-1)-1].
  - wadj=0 when bypass_mode_sel=1.
- Fill rule:
  - Per-channel fill counter saturates at 2^DSW.
  - If fill_count(after write) <= prog_delay_sel: fir_x = 0 and wadj = 0 (delay line not yet primed).
- prog_delay_sel / bypass_mode_sel are sampled in CALC. A change mid-operation affects the next sample only; fill counters are not reset.
- Freeze: no state, counter, pointer or watchdog advances; in_ready=0; a pending fir_go is deferred until freeze falls. fir_done arriving during freeze is still latched (registered flag) and consumed when freeze falls.
- A fir_done outside WAIT is ignored.
- Reset mid-transaction: sequencer returns to IDLE next cycle; the engine is expected to be reset by the same rst.

Decomposition:
- Shared package anc_pkg:
  - DW / DSW defaults.
  - FSM state enum.
  - Saturating round-shift function sat_rshift.
- Sub-module anc_delay_ram:
  - CH x 2^DSW x DW storage with per-channel write pointer and fill counter.
  - 1-cycle write/read with delay-0 bypass.

Test Plan:
- Reset/bring-up: rst, init_done=0 for 10 cycles -> in_ready=0, all outputs 0. init_done=1 -> in_ready=1 one cycle later.
- Basic LMS, CH=2: ch0 e=16384, u=16384, delay=0, x=1000 -> fir_x=1000, fir_wadj=8192, fir_go at T+2. Engine returns fir_y=-77 after 5 cycles -> out_valid, out_ch=0, out_sample=-77.
- Saturation: e=-32768, u=-32768 -> wadj=32767. Same with bypass_mode_sel=1 -> wadj=0.
- Delay/fill, delay=3: ch1 x=1,2,3,4,5 -> fir_x=0,0,0,1,2 with wadj=0 for the first 3 samples. Interleaved ch0 traffic does not disturb the ch1 sequence.
- Timeout, TMO=20: fir_done never asserted -> out_valid at 21 cycles after fir_go with out_sample=0. err_tmo stays 1 until rst.
- Freeze: freeze=1 in CALC for 7 cycles -> fir_go delayed exactly 7 cycles. fir_done pulsed during freeze -> output still produced after release.

Source files
------------

// File: rtl/anc_pkg.sv
// Shared types and arithmetic helpers for the multi-channel ANC sequencer.
package anc_pkg;

   localparam int DW_DEF  = 16;
   localparam int DSW_DEF = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READY,
      S_CALC,
      S_ISSUE,
      S_WAIT,
      S_OUT
   } state_t;

   // Round-half-up shift by dw-1, saturated to a signed dw-bit range.
   function automatic logic signed [63:0] sat_rshift(
      input logic signed [63:0] p,
      input int unsigned        dw
   );
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r  = (p + (64'sd1 <<< (dw - 2))) >>> (dw - 1);
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (r > hi) begin
         return hi;
      end else if (r < lo) begin
         return lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/anc_delay_ram.sv
// Per-channel x delay line with write pointer, fill tracking and
// registered read (delay 0 bypasses to the incoming sample).
module anc_delay_ram
   import anc_pkg::*;
#(
   parameter int CH  = 2,
   parameter int CHW = 1,
   parameter int DW  = DW_DEF,
   parameter int DSW = DSW_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           we,
   input  logic [CHW-1:0] ch,
   input  logic [DW-1:0]  x_in,
   input  logic [DSW-1:0] sel,
   output logic [DW-1:0]  x_out,
   output logic           primed
);

   localparam int DEPTH = 2 ** DSW;

   logic [DW-1:0]  mem [CH][DEPTH];
   logic [DSW-1:0] wptr_q [CH];
   logic [DSW-1:0] wptr_d [CH];
   logic [DSW:0]   fill_q [CH];
   logic [DSW:0]   fill_d [CH];
   logic [DW-1:0]  x_q, x_d;
   logic           primed_q, primed_d;
   logic [DSW:0]   fill_nx;
   logic [DW-1:0]  rd;

   always_comb begin
      wptr_d   = wptr_q;
      fill_d   = fill_q;
      x_d      = x_q;
      primed_d = primed_q;
      fill_nx  = fill_q[ch];
      if (fill_q[ch] != (DSW+1)'(DEPTH)) begin
         fill_nx = fill_q[ch] + (DSW+1)'(1);
      end
      rd = (sel == '0) ? x_in : mem[ch][wptr_q[ch] - sel];
      if (we) begin
         wptr_d[ch] = wptr_q[ch] + DSW'(1);
         fill_d[ch] = fill_nx;
         primed_d   = fill_nx > {1'b0, sel};
         x_d        = primed_d ? rd : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            wptr_q[i] <= '0;
            fill_q[i] <= '0;
         end
         x_q      <= '0;
         primed_q <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         fill_q   <= fill_d;
         x_q      <= x_d;
         primed_q <= primed_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[ch][wptr_q[ch]] <= x_in;
      end
   end

   assign x_out  = x_q;
   assign primed = primed_q;

endmodule

// File: rtl/anc_mc_sequencer.sv
// Multi-channel ANC sequencer sharing one FIR/weight engine via go/done,
// with per-channel x delay, LMS weight adjust and a fir_done watchdog.
module anc_mc_sequencer
   import anc_pkg::*;
#(
   parameter int CH  = 2,
   parameter int DW  = DW_DEF,
   parameter int DSW = DSW_DEF,
   parameter int TMO = 1023,
   localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 freeze,
   input  logic                 init_done,
   input  logic [DSW-1:0]       prog_delay_sel,
   input  logic                 bypass_mode_sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CHW-1:0]       in_ch,
   input  logic signed [DW-1:0] e_in,
   input  logic signed [DW-1:0] x_in,
   input  logic signed [DW-1:0] a_in,
   input  logic signed [DW-1:0] u_in,
   output logic                 fir_go,
   output logic [CHW-1:0]       fir_ch,
   output logic signed [DW-1:0] fir_x,
   output logic signed [DW-1:0] fir_a,
   output logic signed [DW-1:0] fir_wadj,
   input  logic                 fir_done,
   input  logic signed [DW-1:0] fir_y,
   output logic                 out_valid,
   output logic [CHW-1:0]       out_ch,
   output logic signed [DW-1:0] out_sample,
   output logic                 err_tmo
);

   localparam int CW = $clog2(TMO + 1);

   state_t                state_q, state_d;
   logic [CHW-1:0]        ch_q, ch_d;
   logic signed [DW-1:0]  e_q, e_d, x_q, x_d;
   logic signed [DW-1:0]  a_q, a_d, u_q, u_d;
   logic signed [DW-1:0]  wadj_q, wadj_d, y_q, y_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  pend_q, pend_d;
   logic                  tmo_q, tmo_d;
   logic signed [2*DW-1:0] prod;
   logic signed [63:0]    p64;
   logic signed [DW-1:0]  wadj_c;
   logic                  ch_ok, done_eff, ram_we, primed;
   logic [DW-1:0]         ram_x;

   assign prod   = e_q * u_q;
   assign p64    = {{(64-2*DW){prod[2*DW-1]}}, prod};
   assign wadj_c = DW'(sat_rshift(p64, DW));
   assign ch_ok  = 32'(in_ch) < CH;
   assign ram_we = (state_q == S_CALC) && !freeze;

   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      e_d      = e_q;
      x_d      = x_q;
      a_d      = a_q;
      u_d      = u_q;
      wadj_d   = wadj_q;
      y_d      = y_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      tmo_d    = tmo_q;
      done_eff = fir_done | pend_q;
      if (!freeze) begin
         pend_d = 1'b0;
         unique case (state_q)
            S_IDLE: if (init_done) state_d = S_READY;
            S_READY: begin
               if (in_valid && ch_ok) begin
                  ch_d    = in_ch;
                  e_d     = e_in;
                  x_d     = x_in;
                  a_d     = a_in;
                  u_d     = u_in;
                  state_d = S_CALC;
               end
            end
            S_CALC: begin
               wadj_d  = bypass_mode_sel ? '0 : wadj_c;
               state_d = S_ISSUE;
            end
            S_ISSUE: begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (done_eff) begin
                  y_d     = pend_q ? y_q : fir_y;
                  state_d = S_OUT;
               end else if (cnt_q == CW'(TMO - 1)) begin
                  tmo_d   = 1'b1;
                  y_d     = '0;
                  state_d = S_OUT;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_OUT: state_d = init_done ? S_READY : S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end else if (state_q == S_WAIT && fir_done && !pend_q) begin
         // fir_y is only valid with fir_done, so capture it now
         pend_d = 1'b1;
         y_d    = fir_y;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         e_q     <= '0;
         x_q     <= '0;
         a_q     <= '0;
         u_q     <= '0;
         wadj_q  <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         e_q     <= e_d;
         x_q     <= x_d;
         a_q     <= a_d;
         u_q     <= u_d;
         wadj_q  <= wadj_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         tmo_q   <= tmo_d;
      end
   end

   anc_delay_ram #(
      .CH (CH),
      .CHW(CHW),
      .DW (DW),
      .DSW(DSW)
   ) u_dly (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .ch    (ch_q),
      .x_in  (x_q),
      .sel   (prog_delay_sel),
      .x_out (ram_x),
      .primed(primed)
   );

   assign in_ready   = (state_q == S_READY) && !freeze;
   assign fir_go     = (state_q == S_ISSUE) && !freeze;
   assign out_valid  = (state_q == S_OUT) && !freeze;
   assign fir_ch     = ch_q;
   assign fir_x      = ram_x;
   assign fir_a      = a_q;
   assign fir_wadj   = primed ? wadj_q : '0;
   assign out_ch     = ch_q;
   assign out_sample = y_q;
   assign err_tmo    = tmo_q;

endmodule

// File: tb/tb_anc_mc_sequencer.sv
// Directed self-checking bench for anc_mc_sequencer (CH=2, TMO=20).
module tb_anc_mc_sequencer;

   logic               clk = 1'b0;
   logic               rst;
   logic               freeze;
   logic               init_done;
   logic [4:0]         prog_delay_sel;
   logic               bypass_mode_sel;
   logic               in_valid;
   logic               in_ready;
   logic [0:0]         in_ch;
   logic signed [15:0] e_in, x_in, a_in, u_in;
   logic               fir_go;
   logic [0:0]         fir_ch;
   logic signed [15:0] fir_x, fir_a, fir_wadj;
   logic               fir_done;
   logic signed [15:0] fir_y;
   logic               out_valid;
   logic [0:0]         out_ch;
   logic signed [15:0] out_sample;
   logic               err_tmo;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   anc_mc_sequencer #(
      .CH (2),
      .DW (16),
      .DSW(5),
      .TMO(20)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .freeze         (freeze),
      .init_done      (init_done),
      .prog_delay_sel (prog_delay_sel),
      .bypass_mode_sel(bypass_mode_sel),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_ch          (in_ch),
      .e_in           (e_in),
      .x_in           (x_in),
      .a_in           (a_in),
      .u_in           (u_in),
      .fir_go         (fir_go),
      .fir_ch         (fir_ch),
      .fir_x          (fir_x),
      .fir_a          (fir_a),
      .fir_wadj       (fir_wadj),
      .fir_done       (fir_done),
      .fir_y          (fir_y),
      .out_valid      (out_valid),
      .out_ch         (out_ch),
      .out_sample     (out_sample),
      .err_tmo        (err_tmo)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Accept one sample, optionally freeze CALC for fz cycles, check ISSUE.
   task automatic issue(input int ch, input int e, input int x, input int a,
                        input int u, input int fz, input int ex,
                        input int ew);
      chk("rdy_before", 32'(in_ready), 1);
      in_ch    = 1'(ch);
      e_in     = 16'(e);
      x_in     = 16'(x);
      a_in     = 16'(a);
      u_in     = 16'(u);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("go_calc", 32'(fir_go), 0);
      if (fz > 0) begin
         freeze = 1'b1;
         for (int i = 0; i < fz; i++) begin
            step();
            chk("go_frozen", 32'(fir_go), 0);
         end
         freeze = 1'b0;
      end
      step();
      chk("go", 32'(fir_go), 1);
      chk("fir_ch", 32'(fir_ch), ch);
      chk("fir_x", 32'(fir_x), ex);
      chk("fir_a", 32'(fir_a), a);
      chk("fir_wadj", 32'(fir_wadj), ew);
   endtask

   task automatic finish_txn(input int n, input int y, input int ch);
      for (int i = 0; i < n; i++) step();
      fir_done = 1'b1;
      fir_y    = 16'(y);
      step();
      fir_done = 1'b0;
      chk("out_valid", 32'(out_valid), 1);
      chk("out_ch", 32'(out_ch), ch);
      chk("out_sample", 32'(out_sample), y);
      step();
      chk("out_pulse", 32'(out_valid), 0);
      chk("rdy_again", 32'(in_ready), 1);
   endtask

   initial begin
      rst = 1'b1; freeze = 1'b0; init_done = 1'b0;
      prog_delay_sel = '0; bypass_mode_sel = 1'b0;
      in_valid = 1'b0; in_ch = '0;
      e_in = '0; x_in = '0; a_in = '0; u_in = '0;
      fir_done = 1'b0; fir_y = '0;
      repeat (10) step();
      chk("rst_ready", 32'(in_ready), 0);
      chk("rst_go", 32'(fir_go), 0);
      chk("rst_ovalid", 32'(out_valid), 0);
      chk("rst_sample", 32'(out_sample), 0);
      chk("rst_fir_x", 32'(fir_x), 0);
      chk("rst_tmo", 32'(err_tmo), 0);
      rst = 1'b0;
      repeat (3) step();
      chk("idle_ready", 32'(in_ready), 0);
      init_done = 1'b1;
      step();
      chk("bringup_ready", 32'(in_ready), 1);

      issue(0, 16384, 1000, 5, 16384, 0, 1000, 8192);
      finish_txn(5, -77, 0);

      issue(0, -32768, 7, 3, -32768, 0, 7, 32767);
      finish_txn(2, 100, 0);

      bypass_mode_sel = 1'b1;
      issue(0, -32768, 8, 3, -32768, 0, 8, 0);
      bypass_mode_sel = 1'b0;
      finish_txn(2, 200, 0);

      prog_delay_sel = 5'd3;
      issue(1, 16384, 1, 0, 16384, 0, 0, 0);
      finish_txn(1, 11, 1);
      issue(1, 16384, 2, 0, 16384, 0, 0, 0);
      finish_txn(1, 12, 1);
      issue(1, 16384, 3, 0, 16384, 0, 0, 0);
      finish_txn(1, 13, 1);
      issue(0, 16384, 9, 0, 16384, 0, 1000, 8192);
      finish_txn(1, 14, 0);
      issue(1, 16384, 4, 0, 16384, 0, 1, 8192);
      finish_txn(1, 15, 1);
      issue(1, 16384, 5, 0, 16384, 0, 2, 8192);
      finish_txn(1, 16, 1);

      issue(1, 16384, 6, 0, 16384, 0, 3, 8192);
      repeat (20) step();
      chk("tmo_not_yet", 32'(out_valid), 0);
      step();
      chk("tmo_ovalid", 32'(out_valid), 1);
      chk("tmo_sample", 32'(out_sample), 0);
      chk("tmo_flag", 32'(err_tmo), 1);
      step();
      chk("tmo_ready", 32'(in_ready), 1);

      prog_delay_sel = 5'd0;
      issue(0, 16384, 50, 9, 16384, 7, 50, 8192);
      step();
      freeze = 1'b1;
      step();
      step();
      fir_done = 1'b1;
      fir_y    = -16'sd1234;
      step();
      fir_done = 1'b0;
      step();
      chk("frz_no_out", 32'(out_valid), 0);
      freeze = 1'b0;
      step();
      chk("frz_ovalid", 32'(out_valid), 1);
      chk("frz_sample", 32'(out_sample), -1234);
      chk("tmo_sticky", 32'(err_tmo), 1);
      step();

      fir_done = 1'b1;
      fir_y    = 16'sd99;
      step();
      fir_done = 1'b0;
      chk("stray_done", 32'(out_valid), 0);
      chk("stray_ready", 32'(in_ready), 1);

      issue(1, 0, 77, 1, 0, 0, 77, 0);
      step();
      fir_done = 1'b1;
      fir_y    = 16'sd5;
      step();
      fir_done  = 1'b0;
      init_done = 1'b0;
      chk("drop_ovalid", 32'(out_valid), 1);
      step();
      chk("drop_idle", 32'(in_ready), 0);
      init_done = 1'b1;
      step();
      chk("drop_ready", 32'(in_ready), 1);

      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst2_tmo", 32'(err_tmo), 0);
      chk("rst2_sample", 32'(out_sample), 0);
      chk("rst2_fir_x", 32'(fir_x), 0);
      chk("rst2_ready", 32'(in_ready), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
